// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the RV32I memory stage: funct3 size codes, FSM states
// and byte-enable base patterns.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load formatter: selects the addressed byte/half of a bus word and sign- or
// zero-extends it according to the load's funct3.
module load_align
  import mem_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = rdata[{off[1], 4'b0000} +: 16];
    result = rdata;
    case (funct3)
      F3_B:    result = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   result = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    result = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   result = {{(XLEN-16){1'b0}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the RV32I pipeline: turns EX_MEM loads/stores into a registered
// req/ack bus transaction, stalls until completion and formats load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] store_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] mem_data,
  output logic            stall,
  output logic            access_fault
);

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] mem_data_q, mem_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            tmo_q, tmo_d;

  logic            access, legal, aligned, issue;
  logic [3:0]      be_n;
  logic [XLEN-1:0] wdata_n;
  logic [XLEN-1:0] load_res;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .result (load_res)
  );

  // Request decode: a store wins when both read and write are asserted.
  always_comb begin
    access = mem_read | mem_write;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~mem_write;
      default:          legal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~alu_out[0];
      2'b10:   aligned = (alu_out[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    issue = access & legal & aligned;
    case (funct3[1:0])
      2'b00: begin
        be_n    = BE_BYTE << alu_out[1:0];
        wdata_n = {(XLEN/8){store_data[7:0]}};
      end
      2'b01: begin
        be_n    = BE_HALF << {alu_out[1], 1'b0};
        wdata_n = {(XLEN/16){store_data[15:0]}};
      end
      default: begin
        be_n    = BE_WORD;
        wdata_n = store_data;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    mem_data_d   = mem_data_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    off_d        = off_q;
    tmo_d        = tmo_q;
    stall        = 1'b0;
    access_fault = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {alu_out[XLEN-1:2], 2'b00};
          be_d    = be_n;
          wdata_d = wdata_n;
          f3_d    = funct3;
          off_d   = alu_out[1:0];
          cnt_d   = '0;
          state_d = BUS;
        end else if (access) begin
          access_fault = 1'b1;
          mem_data_d   = '0;
        end
      end
      BUS: begin
        stall = 1'b1;
        if (dmem_ack) begin
          req_d = 1'b0;
          if (!we_q) mem_data_d = load_res;
          state_d = DONE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          req_d      = 1'b0;
          mem_data_d = '0;
          tmo_d      = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        // Single non-stalled cycle lets MEM_WB capture; next instruction waits for IDLE.
        access_fault = tmo_q;
        tmo_d        = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      mem_data_q <= '0;
      cnt_q      <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      mem_data_q <= mem_data_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      tmo_q      <= tmo_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign mem_data   = mem_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference model with a small
// byte-addressed memory, per-cycle compare process and directed literal checks.
module tb_mem_access_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_out, store_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_data;
  logic [3:0]  dmem_be;
  logic        dmem_ack, stall, access_fault;

  mem_access_unit #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .alu_out(alu_out), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_data(mem_data), .stall(stall),
    .access_fault(access_fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected state of the unit as seen by the pipeline.
  bit          chk_en = 1'b0;
  bit          exp_stall, exp_fault;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata, m_mem_data;
  logic [3:0]  m_be;

  logic [31:0] mem [int unsigned];
  logic [2:0]  lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(bit wr, logic [2:0] f3);
    if (wr) return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
  endfunction

  function automatic logic [31:0] fmt(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      3'b000:  return (s & 32'hFF) - ((s & 32'h80) << 1);
      3'b100:  return s & 32'hFF;
      3'b001:  return (s & 32'hFFFF) - ((s & 32'h8000) << 1);
      3'b101:  return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] rd_word(logic [31:0] a);
    if (!mem.exists(a >> 2)) mem[a >> 2] = $urandom;
    return mem[a >> 2];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("access_fault", 32'(access_fault), 32'(exp_fault));
      check("dmem_req", 32'(dmem_req), 32'(m_req));
      check("dmem_we", 32'(dmem_we), 32'(m_we));
      check("dmem_addr", dmem_addr, m_addr);
      check("mem_data", mem_data, m_mem_data);
      if (m_we) begin
        check("dmem_be", 32'(dmem_be), 32'(m_be));
        check("dmem_wdata", dmem_wdata, m_wdata);
      end
    end
  end

  // One EX_MEM instruction from first presentation until it leaves MEM.
  // ack_lat = k acks in the (k+1)th BUS cycle; negative means never ack.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata, input int ack_lat,
                        output int st_cyc, output int req_cyc, output int flt_cyc,
                        output logic [3:0] c_be, output logic [31:0] c_wd,
                        output logic [31:0] c_ad, output logic c_we);
    bit acc, ok, tmo, done;
    int sz;
    logic [31:0] rdv, w;
    st_cyc = 0; req_cyc = 0; flt_cyc = 0;
    c_be = '0; c_wd = '0; c_ad = '0; c_we = 1'b0;
    acc = rd | wr;
    sz  = 1 << f3[1:0];
    ok  = acc && is_legal(wr, f3) && ((addr & 32'(sz - 1)) == 0);
    mem_read = rd; mem_write = wr; funct3 = f3; alu_out = addr; store_data = sdata;
    dmem_ack = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    exp_stall = ok;
    exp_fault = acc && !ok;
    #3;
    st_cyc += int'(stall); req_cyc += int'(dmem_req); flt_cyc += int'(access_fault);
    step();
    if (!acc) return;
    if (!ok) begin
      m_mem_data = '0;
      return;
    end
    m_req  = 1'b1;
    m_we   = wr;
    m_addr = addr & 32'hFFFF_FFFC;
    if (wr) begin
      m_be    = 4'(((1 << sz) - 1) << addr[1:0]);
      m_wdata = (sz == 1) ? sdata[7:0] * 32'h0101_0101 :
                (sz == 2) ? sdata[15:0] * 32'h0001_0001 : sdata;
    end
    exp_fault = 1'b0;
    tmo = 1'b0;
    done = 1'b0;
    for (int k = 0; !done && k < 64; k++) begin
      exp_stall  = 1'b1;
      alu_out    = $urandom;
      store_data = $urandom;
      dmem_ack   = (ack_lat >= 0 && k == ack_lat);
      rdv        = rd_word(m_addr);
      dmem_rdata = dmem_ack ? rdv : $urandom;
      #3;
      st_cyc += int'(stall); req_cyc += int'(dmem_req); flt_cyc += int'(access_fault);
      if (k == 0) begin
        c_be = dmem_be; c_wd = dmem_wdata; c_ad = dmem_addr; c_we = dmem_we;
      end
      step();
      if (dmem_ack) begin
        m_req = 1'b0;
        done  = 1'b1;
        if (!wr) m_mem_data = fmt(rdv, addr[1:0], f3);
        else begin
          w = rdv;
          for (int b = 0; b < 4; b++)
            if (m_be[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
          mem[m_addr >> 2] = w;
        end
      end else if (k == TMO - 1) begin
        m_req = 1'b0;
        m_mem_data = '0;
        tmo  = 1'b1;
        done = 1'b1;
      end
    end
    if (!done) check("bus_bound", 32'(done), 32'd1);
    exp_stall  = 1'b0;
    exp_fault  = tmo;
    dmem_ack   = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    #3;
    st_cyc += int'(stall); req_cyc += int'(dmem_req); flt_cyc += int'(access_fault);
    step();
    exp_fault = 1'b0;
  endtask

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int st, rq, fl, t, lat;
    logic [3:0]  cbe;
    logic [31:0] cwd, cad, a;
    logic        cwe, rd, wr;
    logic [2:0]  f3;

    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    alu_out = '0; store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_be = '0; m_wdata = '0; m_mem_data = '0;
    exp_stall = 1'b0; exp_fault = 1'b0;
    step(); step();
    check("rst_req", 32'(dmem_req), 0);
    check("rst_we", 32'(dmem_we), 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", 32'(dmem_be), 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_fault", 32'(access_fault), 0);
    reset = 1'b1;
    step();
    chk_en = 1'b1;

    run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, st, rq, fl, cbe, cwd, cad, cwe);
    check("sw_we", 32'(cwe), 1);
    check("sw_be", 32'(cbe), 32'hF);
    check("sw_addr", cad, 32'h100);
    check("sw_wdata", cwd, 32'hDEADBEEF);
    check("sw_stall_cycles", st, 2);
    run_op(1'b1, 1'b0, 3'b010, 32'h100, $urandom, 0, st, rq, fl, cbe, cwd, cad, cwe);
    check("lw_data", mem_data, 32'hDEADBEEF);
    check("lw_stall_cycles", st, 2);

    mem[32'h40] = 32'h80112233;
    run_op(1'b1, 1'b0, 3'b000, 32'h103, $urandom, 1, st, rq, fl, cbe, cwd, cad, cwe);
    check("lb_data", mem_data, 32'hFFFFFF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h103, $urandom, 2, st, rq, fl, cbe, cwd, cad, cwe);
    check("lbu_data", mem_data, 32'h00000080);
    check("lbu_stall_cycles", st, 4);
    run_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 0, st, rq, fl, cbe, cwd, cad, cwe);
    check("sh_be", 32'(cbe), 32'hC);
    check("sh_wdata", cwd, 32'hABCDABCD);
    check("sh_addr", cad, 32'h100);
    check("sh_keeps_mem_data", mem_data, 32'h00000080);

    run_op(1'b1, 1'b0, 3'b010, 32'h300, $urandom, -1, st, rq, fl, cbe, cwd, cad, cwe);
    check("tmo_req_cycles", rq, 16);
    check("tmo_fault_cycles", fl, 1);
    check("tmo_stall_cycles", st, 17);
    check("tmo_mem_data", mem_data, 0);
    run_op(1'b1, 1'b0, 3'b010, 32'h100, $urandom, 3, st, rq, fl, cbe, cwd, cad, cwe);
    check("lw_after_sh", mem_data, 32'hABCD2233);
    run_op(1'b1, 1'b0, 3'b010, 32'h102, $urandom, 0, st, rq, fl, cbe, cwd, cad, cwe);
    check("mis_fault_cycles", fl, 1);
    check("mis_stall_cycles", st, 0);
    check("mis_req_cycles", rq, 0);
    check("mis_mem_data", mem_data, 0);

    // Reset while a load is waiting on the bus, then a stray ack.
    run_op(1'b1, 1'b0, 3'b010, 32'h100, $urandom, 0, st, rq, fl, cbe, cwd, cad, cwe);
    chk_en = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_out = 32'h204; dmem_ack = 1'b0;
    step(); step();
    check("pre_rst_req", 32'(dmem_req), 1);
    check("pre_rst_stall", 32'(stall), 1);
    #1;
    reset = 1'b0; mem_read = 1'b0;
    #1;
    check("busrst_req", 32'(dmem_req), 0);
    check("busrst_we", 32'(dmem_we), 0);
    check("busrst_addr", dmem_addr, 0);
    check("busrst_mem_data", mem_data, 0);
    check("busrst_stall", 32'(stall), 0);
    m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_be = '0; m_wdata = '0; m_mem_data = '0;
    exp_stall = 1'b0; exp_fault = 1'b0;
    step();
    reset = 1'b1;
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    step();
    dmem_ack = 1'b0;
    check("late_ack_mem_data", mem_data, 0);
    check("late_ack_req", 32'(dmem_req), 0);
    chk_en = 1'b1;

    for (int i = 0; i < 150; i++) begin
      t  = int'($urandom_range(0, 9));
      rd = (t <= 4) || (t == 8);
      wr = (t >= 5) && (t <= 8);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (wr)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = lf[$urandom_range(0, 4)];
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      lat = ($urandom_range(0, 14) == 0) ? -1 : int'($urandom_range(0, 3));
      run_op(rd, wr, f3, a, $urandom, lat, st, rq, fl, cbe, cwd, cad, cwe);
    end
    run_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, st, rq, fl, cbe, cwd, cad, cwe);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
